// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and helpers for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;
    localparam int WB_PORTS   = 2;

    typedef logic                  bool_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        bool_t     live;
        reg_addr_t addr;
        reg_data_t data;
    } wb_entry_t;

    // True when address a is targeted by any enabled lane this cycle.
    function automatic logic addr_hit(
        input reg_addr_t                            a,
        input logic [WB_PORTS-1:0]                  en,
        input logic [WB_PORTS-1:0][REG_ADDR_W-1:0]  lanes
    );
        addr_hit = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (en[i] && lanes[i] == a) begin
                addr_hit = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// rtl/regfile_wb_arbiter_fifo.sv - ordered long-latency result FIFO, 1 push / up to 2 pops per cycle
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  wb_entry_t                             push_entry,
    input  logic [1:0]                            pop_cnt,
    input  logic [WB_PORTS-1:0]                   clr_en,
    input  logic [WB_PORTS-1:0][REG_ADDR_W-1:0]   clr_addr,
    output logic [PTR_W:0]                        count,
    output wb_entry_t [WB_PORTS-1:0]              head,
    output logic [DEPTH-1:0]                      entry_live,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DEPTH-1:0]      kill;

    assign head[0] = mem[rd_ptr];
    assign head[1] = mem[rd_ptr + PTR_W'(1)];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_live[i] = mem[i].live;
            entry_addr[i] = mem[i].addr;
        end
    end

    // Popped slots lose live so the entry array only ever shows queued writes.
    always_comb begin
        kill = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_hit(mem[i].addr, clr_en, clr_addr)) begin
                kill[i] = 1'b1;
            end
            if (pop_cnt != 2'd0 && PTR_W'(i) == rd_ptr) begin
                kill[i] = 1'b1;
            end
            if (pop_cnt == 2'd2 && PTR_W'(i) == rd_ptr + PTR_W'(1)) begin
                kill[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill[i]) begin
                    mem[i].live <= 1'b0;
                end
            end
            if (push) begin
                mem[wr_ptr] <= push_entry;
            end
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
            count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop_cnt);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges two ALU lanes and a queued long-latency unit onto two regfile write ports
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [WB_PORTS-1:0]                   lane_valid,
    input  logic [WB_PORTS-1:0][REG_ADDR_W-1:0]   lane_addr,
    input  logic [WB_PORTS-1:0][REG_DATA_W-1:0]   lane_data,
    input  logic                                  lu_valid,
    output logic                                  lu_ready,
    input  logic [REG_ADDR_W-1:0]                 lu_addr,
    input  logic [REG_DATA_W-1:0]                 lu_data,
    output logic [WB_PORTS-1:0]                   write_ena,
    output logic [WB_PORTS-1:0][REG_ADDR_W-1:0]   write_addr,
    output logic [WB_PORTS-1:0][REG_DATA_W-1:0]   write_data,
    output logic [NUM_REGS-1:0]                   pending_mask
);

    logic [WB_PORTS-1:0]                  eff;
    logic [1:0]                           k;
    logic [1:0]                           free;
    logic [1:0]                           pop_cnt;
    logic [1:0]                           slot;
    logic                                 push;
    wb_entry_t                            push_entry;
    logic [PTR_W:0]                       count;
    wb_entry_t [WB_PORTS-1:0]             head;
    logic [DEPTH-1:0]                     entry_live;
    logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_addr;
    logic [WB_PORTS-1:0]                  nxt_ena;
    logic [WB_PORTS-1:0][REG_ADDR_W-1:0]  nxt_addr;
    logic [WB_PORTS-1:0][REG_DATA_W-1:0]  nxt_data;

    // Lane 1 is younger, so on an address tie lane 0's result is dead.
    assign eff[1] = lane_valid[1] && lane_addr[1] != '0;
    assign eff[0] = lane_valid[0] && lane_addr[0] != '0 &&
                    !(eff[1] && lane_addr[0] == lane_addr[1]);

    assign k        = {1'b0, eff[0]} + {1'b0, eff[1]};
    assign free     = 2'd2 - k;
    assign pop_cnt  = (count < (PTR_W+1)'(free)) ? 2'(count) : free;
    assign lu_ready = count < (PTR_W+1)'(DEPTH);
    assign push     = lu_valid && lu_ready;

    assign push_entry.live = lu_addr != '0 && !addr_hit(lu_addr, eff, lane_addr);
    assign push_entry.addr = lu_addr;
    assign push_entry.data = lu_data;

    wb_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop_cnt    (pop_cnt),
        .clr_en     (eff),
        .clr_addr   (lane_addr),
        .count      (count),
        .head       (head),
        .entry_live (entry_live),
        .entry_addr (entry_addr)
    );

    // Popped entries take the low ports; a same-cycle lane hit kills the older value.
    always_comb begin
        nxt_ena  = '0;
        nxt_addr = '0;
        nxt_data = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            if (2'(p) < pop_cnt && head[p].live &&
                !addr_hit(head[p].addr, eff, lane_addr)) begin
                nxt_ena[p]  = 1'b1;
                nxt_addr[p] = head[p].addr;
                nxt_data[p] = head[p].data;
            end
        end
        slot = pop_cnt;
        for (int l = 0; l < WB_PORTS; l++) begin
            if (eff[l]) begin
                nxt_ena[slot[0]]  = 1'b1;
                nxt_addr[slot[0]] = lane_addr[l];
                nxt_data[slot[0]] = lane_data[l];
                slot = slot + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_ena  <= '0;
            write_addr <= '0;
            write_data <= '0;
        end else begin
            write_ena  <= nxt_ena;
            write_addr <= nxt_addr;
            write_data <= nxt_data;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_live[i]) begin
                pending_mask = pending_mask | (NUM_REGS'(1) << entry_addr[i]);
            end
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - randomized and directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       lane_valid;
    logic [1:0][4:0]  lane_addr;
    logic [1:0][31:0] lane_data;
    logic             lu_valid;
    logic             lu_ready;
    logic [4:0]       lu_addr;
    logic [31:0]      lu_data;
    logic [1:0]       write_ena;
    logic [1:0][4:0]  write_addr;
    logic [1:0][31:0] write_data;
    logic [31:0]      pending_mask;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lane_valid   (lane_valid),
        .lane_addr    (lane_addr),
        .lane_data    (lane_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .write_ena    (write_ena),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .pending_mask (pending_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ment_t;

    ment_t       q[$];
    logic [1:0]  exp_ena;
    logic [4:0]  exp_addr[2];
    logic [31:0] exp_data[2];
    bit          chk_en;
    int          vectors;
    int          checks;
    int          miscompares;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit hit(input logic [4:0] a, input bit e0, input logic [4:0] a0,
                               input bit e1, input logic [4:0] a1);
        return (e0 && a == a0) || (e1 && a == a1);
    endfunction

    initial begin
        logic [31:0] pm;
        forever begin
            @(posedge clk);
            #1;
            if (chk_en) begin
                pm = '0;
                foreach (q[i]) if (q[i].live) pm[q[i].addr] = 1'b1;
                check("write_ena", write_ena, exp_ena);
                check("port0", {write_addr[0], write_data[0]}, {exp_addr[0], exp_data[0]});
                check("port1", {write_addr[1], write_data[1]}, {exp_addr[1], exp_data[1]});
                check("pending_mask", pending_mask, pm);
                check("lu_ready", lu_ready, q.size() < DEPTH);
            end
        end
    end

    // Apply one cycle of inputs at the falling edge and advance the queue model.
    task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit luv, input logic [4:0] lua, input logic [31:0] lud);
        bit    e0, e1, push;
        int    k, p, port;
        ment_t ent;
        @(negedge clk);
        lane_valid   = {v1, v0};
        lane_addr[0] = a0;
        lane_addr[1] = a1;
        lane_data[0] = d0;
        lane_data[1] = d1;
        lu_valid     = luv;
        lu_addr      = lua;
        lu_data      = lud;
        vectors++;
        e1   = v1 && a1 != 0;
        e0   = v0 && a0 != 0 && !(e1 && a0 == a1);
        k    = int'(e0) + int'(e1);
        push = luv && q.size() < DEPTH;
        p    = (q.size() < 2 - k) ? q.size() : 2 - k;
        exp_ena  = '0;
        exp_addr = '{default: '0};
        exp_data = '{default: '0};
        port = 0;
        repeat (p) begin
            ent = q.pop_front();
            if (ent.live && !hit(ent.addr, e0, a0, e1, a1)) begin
                exp_ena[port]  = 1'b1;
                exp_addr[port] = ent.addr;
                exp_data[port] = ent.data;
            end
            port++;
        end
        if (e0) begin
            exp_ena[port] = 1'b1; exp_addr[port] = a0; exp_data[port] = d0; port++;
        end
        if (e1) begin
            exp_ena[port] = 1'b1; exp_addr[port] = a1; exp_data[port] = d1;
        end
        foreach (q[i]) if (hit(q[i].addr, e0, a0, e1, a1)) q[i].live = 1'b0;
        if (push) begin
            ent.live = lua != 0 && !hit(lua, e0, a0, e1, a1);
            ent.addr = lua;
            ent.data = lud;
            q.push_back(ent);
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic zero_inputs();
        lane_valid = '0; lane_addr = '0; lane_data = '0;
        lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        chk_en = 1'b0;
        zero_inputs();
        exp_ena = '0;
        exp_addr = '{default: '0};
        exp_data = '{default: '0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        settle();
        check("reset_write_ena", write_ena, 2'b00);
        check("reset_pending", pending_mask, 32'h0);
        check("reset_lu_ready", lu_ready, 1'b1);

        drive(1, 3, 'h11, 1, 4, 'h22, 0, 0, 0);
        settle();
        check("t1_ena", write_ena, 2'b11);
        check("t1_port0", {write_addr[0], write_data[0]}, {5'd3, 32'h11});
        check("t1_port1", {write_addr[1], write_data[1]}, {5'd4, 32'h22});

        drive(0, 0, 0, 0, 0, 0, 1, 5, 'hA);
        settle();
        check("t2_pend_r5", pending_mask, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 1, 6, 'hB);
        settle();
        check("t2_ena_r5", write_ena, 2'b01);
        check("t2_port0_r5", {write_addr[0], write_data[0]}, {5'd5, 32'hA});
        check("t2_pend_r6", pending_mask, 32'h40);
        idle();
        settle();
        check("t2_port0_r6", {write_addr[0], write_data[0]}, {5'd6, 32'hB});

        for (int i = 0; i < 4; i++) drive(1, 1, 'h100 + i, 1, 2, 'h200 + i, 1, 5'(10 + i), 'h300 + i);
        settle();
        check("t3_full_ready", lu_ready, 1'b0);
        check("t3_full_pend", pending_mask, 32'h3C00);
        drive(1, 1, 'h104, 1, 2, 'h204, 1, 30, 'h3FF);
        settle();
        check("t3_busy_port0", {write_addr[0], write_data[0]}, {5'd1, 32'h104});
        idle();
        settle();
        check("t3_drain1_port0", {write_addr[0], write_data[0]}, {5'd10, 32'h300});
        check("t3_drain1_port1", {write_addr[1], write_data[1]}, {5'd11, 32'h301});
        idle();
        settle();
        check("t3_drain2_port1", {write_addr[1], write_data[1]}, {5'd13, 32'h303});
        check("t3_ready_back", lu_ready, 1'b1);

        drive(1, 1, 'h1, 1, 2, 'h2, 1, 7, 'h1);
        settle();
        check("t4_pend_r7", pending_mask, 32'h80);
        drive(1, 7, 'h2, 1, 8, 'h3, 0, 0, 0);
        settle();
        check("t4_pend_clear", pending_mask, 32'h0);
        check("t4_lane_r7", {write_addr[0], write_data[0]}, {5'd7, 32'h2});
        idle();
        settle();
        check("t4_dead_pop", write_ena, 2'b00);

        drive(1, 9, 'h90, 1, 9, 'h91, 0, 0, 0);
        settle();
        check("t5_tie_ena", write_ena, 2'b01);
        check("t5_tie_port0", {write_addr[0], write_data[0]}, {5'd9, 32'h91});
        drive(1, 0, 'h55, 0, 0, 0, 1, 0, 'h66);
        settle();
        check("t5_addr0_ena", write_ena, 2'b00);
        check("t5_addr0_pend", pending_mask, 32'h0);
        idle();
        settle();
        check("t5_addr0_pop", write_ena, 2'b00);

        for (int i = 0; i < 3; i++) drive(1, 1, 'h1, 1, 2, 'h2, 1, 5'(20 + i), 'h500 + i);
        settle();
        check("t6_pend", pending_mask, 32'h700000);
        #1;
        rst_n = 1'b0;
        zero_inputs();
        #1;
        check("t6_async_ena", write_ena, 2'b00);
        check("t6_async_pend", pending_mask, 32'h0);
        q.delete();
        exp_ena = '0;
        exp_addr = '{default: '0};
        exp_data = '{default: '0};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) idle();
        settle();
        check("t6_no_stale", write_ena, 2'b00);
        check("t6_ready", lu_ready, 1'b1);

        for (int n = 0; n < 3000; n++) begin
            int thr;
            int amax;
            thr  = (n / 300) % 4 * 30;
            amax = (n % 2 == 1) ? 7 : 31;
            drive($urandom_range(0, 99) < thr, 5'($urandom_range(0, amax)), $urandom,
                  $urandom_range(0, 99) < thr, 5'($urandom_range(0, amax)), $urandom,
                  $urandom_range(0, 99) < 70, 5'($urandom_range(0, amax)), $urandom);
        end
        repeat (3) idle();
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer-side front end for the dual-write-port register file.
- Merges three result sources into the register file's two write ports:
  - two in-order ALU lanes, which have priority and are never back-pressured;
  - one long-latency unit (mul/div/load) behind a small ordered FIFO.
- Also publishes a pending mask so issue logic can stall on registers with queued writes.

Parameters:
- DEPTH, 4, long-latency FIFO entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- lane_valid  input  bool[1:0]  ALU lane result valid; lane 1 is younger than lane 0.
- lane_addr  input  REG_ADDR[1:0]  lane destination register.
- lane_data  input  REG_WIDTH[1:0]  lane result.
- lu_valid  input  bool  long-latency result offered.
- lu_ready  output  bool  FIFO can accept a result; transfer occurs when lu_valid and lu_ready are both 1.
- lu_addr  input  REG_ADDR  long-latency destination register.
- lu_data  input  REG_WIDTH  long-latency result.
- write_ena  output  bool[1:0]  to regfile write_ena.
- write_addr  output  REG_ADDR[1:0]  to regfile write_addr.
- write_data  output  REG_WIDTH[1:0]  to regfile write_data.
- pending_mask  output  32  bit r = 1 when any live FIFO entry targets register r.

Behaviour:
- Reset (async, rst_n=0):
  - write_ena=0, write_addr=0, write_data=0;
  - FIFO empty, all live bits 0;
  - pending_mask=0, lu_ready=1 once reset is released.
  - Reset mid-operation drops all queued entries; no write is issued after reset.
- Write outputs are registered: the decision made in cycle N appears on write_* in cycle N+1, with no combinational input-to-output path.
- Effective lanes:
  - A lane is effective when lane_valid=1 and lane_addr!=0.
  - If both lanes are effective with equal addresses, lane 0 is suppressed; the younger lane 1 wins.
  - k = number of effective lanes (0..2).
- FIFO entry fields: {live, addr, data}.
- Push:
  - lu_ready = (count < DEPTH), from registered count; no push while full, even if a pop happens the same cycle.
  - The pushed entry has live=1 unless lu_addr==0, or lu_addr equals an effective lane address in the same cycle; then live=0. The lane is treated as younger.
- Supersede: each cycle, every stored entry whose addr equals an effective lane address has live cleared. Pending older results never overwrite newer lane values.
- Pop:
  - P = min(2-k, count) entries are popped from the head in order.
  - A popped entry consumes a port slot even when live=0; its port ena is then 0.
- Port assignment, oldest first:
  - popped FIFO entries take ports 0 upward;
  - effective lanes fill the remaining ports, lane 0 before lane 1.
  - Unused ports: ena=0, addr=0, data=0.
- The same-cycle push and pop count update is count + push - P. Pointers wrap modulo DEPTH.
- pending_mask is the OR of one-hot(addr) over live entries, computed from registered state. It excludes entries being pushed this cycle and includes entries popping this cycle.
- Bit 0 of pending_mask is always 0.
- Entries are never reordered. At most 2 writes per cycle.

Decomposition:
- Shared package additions:
  - REG_ADDR, REG_WIDTH, bool are reused from the common defines;
  - add WB_PORTS=2 and a wb_entry_t struct {bool live; REG_ADDR addr; REG_WIDTH data;}.
- One sub-module: wb_fifo.
  - Parameter DEPTH.
  - Ports: 2-pop/1-push, plus a per-entry address-match clear input.
  - Exposes its entry array to drive pending_mask.
- Port selection and lane suppression stay in the top.

Test Plan:
1. Reset, then lane0 {r3, 0x11} and lane1 {r4, 0x22} in one cycle -> next cycle write_ena=2'b11, ports carry (r3,0x11) and (r4,0x22); pending_mask=0.
2. Idle lanes; push lu {r5, 0xA}, then {r6, 0xB} on consecutive cycles:
   - pending_mask bit 5 is set the cycle after the push;
   - r5 is written one cycle after it enters the FIFO, on port 0 with ena=2'b01;
   - r6 follows one cycle later.
3. Hold both lanes effective every cycle and push DEPTH=4 entries:
   - lu_ready drops to 0 after 4 accepts;
   - no FIFO write occurs while both lanes stay busy;
   - release lanes -> 2 entries drain per cycle, lu_ready returns to 1.
4. Queue {r7, 0x1}, then lane0 writes {r7, 0x2} before the drain:
   - pending_mask bit 7 clears;
   - the entry later pops with write_ena=0;
   - the final r7 write observed is 0x2 only.
5. Addr-zero and conflict cases:
   - lane0=lane1=r9 -> only lane 1's data is written;
   - lane addr 0 -> no write;
   - lu push with addr 0 -> consumes a slot, never writes, never sets pending.
6. Assert rst_n=0 asynchronously with 3 queued entries and pending bits set:
   - write_ena and pending_mask go to 0 immediately;
   - after release, no stale writes occur and lu_ready=1.
